prg_scan: RTL and testbench
===========================

# prg_scan

Pixel scan sequencer that sits directly upstream of the primary-ray generator pipeline. It generates the one-hot three-phase slot strobes `v0`/`v1`/`v2` and the raster coordinates `x`/`y` that the generator consumes. It tracks each issued slot through the generator's fixed latency and emits an aligned `rayReady` pulse with a `pixelID` tag. It stops issuing while downstream asserts `stall`, and pulses `frame_done` once the last ray has left the generator.

## Interface
- `NUM_COLS`, 640: raster width in pixels.
- `NUM_ROWS`, 480: raster height in pixels.
- `PRG_LAT`, 40: cycles from the `v0` cycle of a slot to the cycle its ray direction is valid at the generator output; must be ≥3.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one frame; level, sampled in IDLE only.
- `stall` in 1: downstream cannot accept a ray; sampled only on `v0` cycles.
- `v0`, `v1`, `v2` out 1 each: one-hot slot phase strobes.
- `x` out clog2(NUM_COLS): column of the current slot.
- `y` out clog2(NUM_ROWS): row of the current slot.
- `rayReady` out 1: single-cycle pulse, generator output is valid for `pixelID`.
- `pixelID` out clog2(NUM_COLS*NUM_ROWS): `y*NUM_COLS+x` of the ray on `rayReady`.
- `busy` out 1: high in RUN and DRAIN.
- `frame_done` out 1: single-cycle pulse at the end of DRAIN.

## Operation
- **Phase ring**
  - 3-bit one-hot rotation v0→v1→v2→v0, every cycle, in every state.
  - It never stops: the generator pipeline relies on a continuous phase order.
  - A slot is one v0, v1, v2 triple.
- **FSM states**
  - IDLE: `busy`=0. `start`=1 → RUN next cycle; x, y and the pixel counter are cleared on entry.
  - RUN: the slot is *issued* when `v0`=1 and `stall`=0. A skipped slot leaves x and y unchanged and produces no tag.
    - On the `v2` cycle of an issued slot, x and y advance: x+1; when x=NUM_COLS-1, x→0 and y+1.
    - When the issued slot is pixel (NUM_COLS-1, NUM_ROWS-1), x and y hold and the FSM goes to DRAIN at that `v2` edge.
  - DRAIN: no issue. Stays until the tag delay line is empty. It then pulses `frame_done` for one cycle and returns to IDLE.
- **Tag delay line**
  - Shift register, PRG_LAT deep, of {valid, pixelID}.
  - Loaded on the issuing `v0` cycle with {1, running pixel count}.
  - Pixel count is an incrementing counter, not a multiplier.
  - Output drives `rayReady` and `pixelID`. `pixelID` holds its last value when `rayReady`=0.
- `start` in RUN or DRAIN is ignored; no queuing.
- Since `stall` is sampled only at `v0`, a mid-slot `stall` never aborts the slot.
- `stall` has no effect on rays already in flight. Downstream must assert it at least PRG_LAT cycles of headroom early.

## Timing
- **Reset values:** ring = `v0`=1, `v1`=0, `v2`=0; `x`=0, `y`=0, `rayReady`=0, `pixelID`=0, `busy`=0, `frame_done`=0; state IDLE; delay line all invalid.
- **After reset release:** first cycle has `v0`=1.
- **Start latency:** `start` high at cycle t (IDLE) → `busy`=1 at t+1. First issue at the first `v0` cycle ≥ t+1 with `stall`=0.
- **Ray latency:** issue at `v0` cycle c → `rayReady`=1 at c+PRG_LAT. Successive unstalled rays are exactly 3 cycles apart.
- **x/y stability:** constant from a `v0` through the following `v2`; they change only on the clock edge closing `v2`.
- **Frame end:** last issue at c → last `rayReady` at c+PRG_LAT → `frame_done` at c+PRG_LAT+1, `busy` low the same cycle → IDLE.
- **Back-to-back frames:** `start` held high at `frame_done` begins a new frame on the next cycle.
- **Reset mid-frame:** asynchronously returns all state to reset values. In-flight tags are discarded; no `rayReady` or `frame_done` follows.

## Test plan
- **Reset:** assert `rst`=0 mid-run, release → all outputs at reset values, `v0`=1 on the first cycle, `busy`=0.
- **Small frame:** NUM_COLS=4, NUM_ROWS=2, PRG_LAT=7, `stall`=0, `start` pulsed → 8 `rayReady` pulses 3 cycles apart, `pixelID` 0..7, first pulse 7 cycles after the first issuing `v0`, one `frame_done` one cycle after the last pulse.
- **Stall:** same frame, `stall`=1 on the `v0` of pixel 2 for two slots → x=2, y=0 held 9 cycles; `pixelID` 2 arrives 6 cycles later than unstalled; total pulses still 8.
- **Mid-slot stall:** `stall` raised on a `v1` cycle and dropped before the next `v0` → no slot skipped, timing identical to the unstalled run.
- **Start ignored:** `start` pulsed in RUN and in DRAIN → exactly one `frame_done`, no restart.
- **Raster wrap:** 640×480 defaults → `pixelID` 639 is followed by 640 with `y`=1, `x`=0; last `pixelID`=307199; `frame_done` after it; x and y cleared on the next `start`.

Source files
------------

// File: rtl/prg_scan.sv
// rtl/prg_scan.sv - primary-ray scan sequencer: phase ring, raster walk, latency-matched ray tags
module prg_scan #(
    parameter int NUM_COLS = 640,
    parameter int NUM_ROWS = 480,
    parameter int PRG_LAT  = 40
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  stall,
    output logic                                  v0,
    output logic                                  v1,
    output logic                                  v2,
    output logic [$clog2(NUM_COLS)-1:0]           x,
    output logic [$clog2(NUM_ROWS)-1:0]           y,
    output logic                                  rayReady,
    output logic [$clog2(NUM_COLS*NUM_ROWS)-1:0]  pixelID,
    output logic                                  busy,
    output logic                                  frame_done
);
    localparam int XW    = $clog2(NUM_COLS);
    localparam int YW    = $clog2(NUM_ROWS);
    localparam int PW    = $clog2(NUM_COLS*NUM_ROWS);
    // The output register supplies the last cycle of latency.
    localparam int TAG_D = PRG_LAT - 1;
    localparam logic [XW-1:0] X_LAST = XW'(NUM_COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        ring;
    logic              slot_issued;
    logic              issue;
    logic              last_pix;
    logic              frame_end;
    logic [PW-1:0]     pix_cnt;
    logic [TAG_D-1:0]  tag_vld;
    logic [PW-1:0]     tag_pix [TAG_D];

    assign {v2, v1, v0} = ring;
    assign busy         = (state != IDLE);
    assign issue        = (state == RUN) && v0 && !stall;
    assign last_pix     = (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (v2 && slot_issued && last_pix) state_nxt = DRAIN;
            DRAIN: begin
                if (~|tag_vld) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring        <= 3'b001;
            x           <= '0;
            y           <= '0;
            pix_cnt     <= '0;
            slot_issued <= 1'b0;
            tag_vld     <= '0;
            rayReady    <= 1'b0;
            pixelID     <= '0;
            frame_done  <= 1'b0;
        end else begin
            ring       <= {ring[1:0], ring[2]};
            frame_done <= frame_end;
            tag_vld    <= {tag_vld[TAG_D-2:0], issue};
            rayReady   <= tag_vld[TAG_D-1];
            if (tag_vld[TAG_D-1]) pixelID <= tag_pix[TAG_D-1];

            if (state == IDLE && start) begin
                x           <= '0;
                y           <= '0;
                pix_cnt     <= '0;
                slot_issued <= 1'b0;
            end else if (issue) begin
                slot_issued <= 1'b1;
                pix_cnt     <= pix_cnt + 1'b1;
            end else if (v2) begin
                slot_issued <= 1'b0;
                // Raster position holds on the final pixel so it stays visible through DRAIN.
                if (slot_issued && !last_pix) begin
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end
        end
    end

    // Tag payload needs no reset: only entries flagged in tag_vld are ever consumed.
    always_ff @(posedge clk) begin
        tag_pix[0] <= pix_cnt;
        for (int i = 1; i < TAG_D; i++) tag_pix[i] <= tag_pix[i-1];
    end

endmodule

// File: tb/tb_prg_scan.sv
// tb/tb_prg_scan.sv - self-checking bench for prg_scan against a timeline-based reference model
module tb_prg_scan;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int LAT  = 7;
    localparam int NPIX = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       v0, v1, v2;
    logic [1:0] x;
    logic [0:0] y;
    logic       rayReady;
    logic [2:0] pixelID;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    prg_scan #(.NUM_COLS(COLS), .NUM_ROWS(ROWS), .PRG_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .v0(v0), .v1(v1), .v2(v2), .x(x), .y(y),
        .rayReady(rayReady), .pixelID(pixelID), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int due;
        int pid;
    } flight_t;

    flight_t m_q[$];
    int      m_cyc, m_issued, m_closed, m_done_at, m_last_pid;
    bit      m_active;

    int n_pass = 0;
    int n_tot  = 0;
    int cur_c  = 0;
    int mode   = 0;
    int mon_t[$];
    int mon_p[$];
    int mon_done[$];
    int xy2;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (mode %0d cycle %0d)", nm, act, exp, mode, cur_c);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cyc      = 0;
        m_issued   = 0;
        m_closed   = 0;
        m_done_at  = -1;
        m_last_pid = 0;
        m_active   = 1'b0;
    endtask

    // Frame = window from accepted start until one cycle after the last ray is delivered.
    task automatic model_step(input bit st, input bit sl);
        int  ph;
        bit  was_active;
        ph         = m_cyc % 3;
        was_active = m_active;
        if (!was_active && st) begin
            m_active = 1'b1;
            m_issued = 0;
            m_closed = 0;
        end else if (was_active && m_issued < NPIX && ph == 0 && !sl) begin
            m_q.push_back('{due: m_cyc + LAT, pid: m_issued});
            m_issued++;
        end
        if (was_active && ph == 2) m_closed = m_issued;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            m_last_pid = m_q[0].pid;
            void'(m_q.pop_front());
            if (m_active && m_issued == NPIX && m_q.size() == 0) begin
                m_active  = 1'b0;
                m_done_at = m_cyc + 1;
            end
        end
        m_cyc++;
    endtask

    task automatic cycle(input bit r, input bit st, input bit sl);
        rst   = r;
        start = st;
        stall = sl;
        if (!r) model_reset();
        @(posedge clk);
        if (rst) model_step(st, sl);
        else     model_reset();
        #1;
    endtask

    always @(negedge clk) begin : compare
        int  ph, shown;
        bit  ray_e;
        ph    = m_cyc % 3;
        ray_e = (m_q.size() > 0) && (m_q[0].due == m_cyc);
        shown = (m_closed < NPIX) ? m_closed : NPIX - 1;
        chk("v0", int'(v0), int'(ph == 0));
        chk("v1", int'(v1), int'(ph == 1));
        chk("v2", int'(v2), int'(ph == 2));
        chk("x", int'(x), shown % COLS);
        chk("y", int'(y), shown / COLS);
        chk("busy", int'(busy), int'(m_active));
        chk("frame_done", int'(frame_done), int'(m_cyc == m_done_at));
        chk("rayReady", int'(rayReady), int'(ray_e));
        chk("pixelID", int'(pixelID), ray_e ? m_q[0].pid : m_last_pid);
        if (rayReady) begin
            mon_t.push_back(cur_c);
            mon_p.push_back(int'(pixelID));
        end
        if (frame_done) mon_done.push_back(cur_c);
        if (busy && x == 2'd2 && y == 1'b0) xy2++;
        if (mode == 4 && cur_c == 17) chk("release_v0", int'(v0), 1);
    end

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic run_dir(input int md);
        bit r, st, sl;
        mode = md;
        cur_c = -1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        mon_t.delete();
        mon_p.delete();
        mon_done.delete();
        xy2 = 0;
        for (int c = 0; c < 60; c++) begin
            cur_c = c;
            r  = !(md == 4 && (c == 15 || c == 16));
            st = (c == 0) || (md == 3 && (c == 10 || c == 29));
            sl = (md == 1 && (c == 9 || c == 12)) ||
                 (md == 2 && (c == 4 || c == 5 || c == 19));
            cycle(r, st, sl);
        end
    endtask

    initial begin
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rst_v0", int'(v0), 1);
        chk("rst_v1v2", int'({v1, v2}), 0);
        chk("rst_xy", int'({x, y}), 0);
        chk("rst_ray", int'(rayReady), 0);
        chk("rst_pid", int'(pixelID), 0);
        chk("rst_busy_done", int'({busy, frame_done}), 0);

        run_dir(0);
        chk("d0_count", mon_t.size(), 8);
        chk("d0_first", at(mon_t, 0), 10);
        chk("d0_last", at(mon_t, 7), 31);
        for (int i = 0; i < 8; i++) chk("d0_pid", at(mon_p, i), i);
        for (int i = 1; i < 8; i++) chk("d0_gap", at(mon_t, i) - at(mon_t, i-1), 3);
        chk("d0_done_n", mon_done.size(), 1);
        chk("d0_done_t", at(mon_done, 0), 32);
        chk("d0_x2_cycles", xy2, 3);

        run_dir(1);
        chk("d1_count", mon_t.size(), 8);
        chk("d1_pid2", at(mon_p, 2), 2);
        chk("d1_pid2_t", at(mon_t, 2), 22);
        chk("d1_done_t", at(mon_done, 0), 38);
        chk("d1_x2_cycles", xy2, 9);

        run_dir(2);
        chk("d2_first", at(mon_t, 0), 10);
        chk("d2_last", at(mon_t, 7), 31);
        chk("d2_done_t", at(mon_done, 0), 32);

        run_dir(3);
        chk("d3_count", mon_t.size(), 8);
        chk("d3_done_n", mon_done.size(), 1);
        chk("d3_done_t", at(mon_done, 0), 32);

        run_dir(4);
        chk("d4_rays", mon_t.size(), 2);
        chk("d4_done_n", mon_done.size(), 0);

        mode = 5;
        cur_c = 0;
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            cur_c = i;
            cycle($urandom_range(0, 999) >= 3,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
